store_buffer: RTL and testbench

- Posted-write buffer between the CPU data-memory store port (memwrite/dataadr/writedata) and data memory.
- Absorbs CPU stores into a small in-order FIFO and drains them to memory over a valid/ready handshake.
- Stalls the CPU only when full.
- Returns the youngest matching buffered value to loads (store-to-load forwarding), so the CPU never reads stale memory.

---
 rtl/sb_pkg.sv | 16 +
 rtl/store_buffer_if.sv | 39 +++
 rtl/sb_fifo_mem.sv | 71 +++++++
 rtl/store_buffer.sv | 101 ++++++++++
 tb/tb_store_buffer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer: default geometry,
// the buffered entry layout, and where the word-offset bits start.
package sb_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;
    localparam int WORD_LSB = 2;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bundles the CPU store/load-lookup port and the memory drain handshake.
// The slave side is the store buffer; the master side is the CPU plus memory.
interface store_buffer_if
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          stall;
    logic          misalign;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          empty;
    logic [CW-1:0] count;

    modport slave (
        input  memwrite, dataadr, writedata, ld_addr, mem_ready,
        output stall, misalign, ld_hit, ld_data,
               mem_valid, mem_addr, mem_wdata, empty, count
    );

    modport master (
        output memwrite, dataadr, writedata, ld_addr, mem_ready,
        input  stall, misalign, ld_hit, ld_data,
               mem_valid, mem_addr, mem_wdata, empty, count
    );

endinterface

// File: rtl/sb_fifo_mem.sv
// In-order entry storage for the store buffer. Keeps head/tail pointers,
// occupancy and a per-slot valid bit so the parent can scan every
// occupied slot for load forwarding.
module sb_fifo_mem
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = SB_PTR_W,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr,
    input  logic [AW-1:0]             i_wrAddr,
    input  logic [DW-1:0]             i_wrData,
    input  logic                      i_rd,
    output logic [PTR_W-1:0]          o_headPtr,
    output logic [PTR_W:0]            o_count,
    output logic [DEPTH-1:0]          o_valid,
    output logic [DEPTH-1:0][AW-1:0]  o_addr,
    output logic [DEPTH-1:0][DW-1:0]  o_data
);

    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [PTR_W:0]           r_count;
    logic [DEPTH-1:0]         r_valid;
    logic [DEPTH-1:0][AW-1:0] r_addr;
    logic [DEPTH-1:0][DW-1:0] r_data;

    // Pointer, occupancy and slot-valid bookkeeping; reset discards everything pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (i_wr) begin
                r_tail          <= r_tail + 1'b1;
                r_valid[r_tail] <= 1'b1;
            end
            if (i_rd) begin
                r_head          <= r_head + 1'b1;
                r_valid[r_head] <= 1'b0;
            end
            case ({i_wr, i_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: a slot is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_addr[r_tail] <= i_wrAddr;
            r_data[r_tail] <= i_wrData;
        end
    end

    assign o_headPtr = r_head;
    assign o_count   = r_count;
    assign o_valid   = r_valid;
    assign o_addr    = r_addr;
    assign o_data    = r_data;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the CPU store port and data memory.
// Accepts aligned stores into a FIFO, drains them over valid/ready,
// stalls only when full and forwards the youngest matching store to loads.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
)
(
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_misal;
    logic                     w_acc;
    logic                     w_deq;
    logic [PTR_W-1:0]         w_headPtr;
    logic [CW-1:0]            w_count;
    logic [DEPTH-1:0]         w_valid;
    logic [DEPTH-1:0][AW-1:0] w_addr;
    logic [DEPTH-1:0][DW-1:0] w_data;
    logic                     w_fwdHit;
    logic [DW-1:0]            w_fwdData;
    logic [PTR_W-1:0]         w_scanIdx;
    logic                     w_unusedLdLsb;
    logic                     r_misalign;

    sb_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (w_acc),
        .i_wrAddr  (bus.dataadr),
        .i_wrData  (bus.writedata),
        .i_rd      (w_deq),
        .o_headPtr (w_headPtr),
        .o_count   (w_count),
        .o_valid   (w_valid),
        .o_addr    (w_addr),
        .o_data    (w_data)
    );

    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == CW'(DEPTH));
    assign w_misal = bus.memwrite & (bus.dataadr[WORD_LSB-1:0] != '0);

    // Full blocks the enqueue even if the head leaves this cycle, so stall never depends on mem_ready.
    assign w_acc = bus.memwrite & ~w_full & ~w_misal;
    assign w_deq = ~w_empty & bus.mem_ready;

    assign bus.stall     = bus.memwrite & w_full & ~w_misal;
    assign bus.misalign  = r_misalign;
    assign bus.mem_valid = ~w_empty;
    assign bus.empty     = w_empty;
    assign bus.count     = w_count;
    assign bus.mem_addr  = w_empty ? '0 : w_addr[w_headPtr];
    assign bus.mem_wdata = w_empty ? '0 : w_data[w_headPtr];

    // Loads compare whole words, so the byte-offset bits of ld_addr play no part.
    assign w_unusedLdLsb = ^bus.ld_addr[WORD_LSB-1:0];

    // A dropped misaligned store is reported one cycle later as a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misal;
        end
    end

    // Walk the occupied slots oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        w_fwdHit  = 1'b0;
        w_fwdData = '0;
        w_scanIdx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scanIdx = w_headPtr + PTR_W'(k);
            if (w_valid[w_scanIdx] &&
                (w_addr[w_scanIdx][AW-1:WORD_LSB] == bus.ld_addr[AW-1:WORD_LSB])) begin
                w_fwdHit  = 1'b1;
                w_fwdData = w_data[w_scanIdx];
            end
        end
    end

    assign bus.ld_hit  = w_fwdHit;
    assign bus.ld_data = w_fwdData;

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the buffer.
module tb_store_buffer;
    import sb_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) sbIf();

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sbIf.slave)
    );

    int        checks   = 0;
    int        failures = 0;
    bit        checkEn  = 1'b0;
    sb_entry_t modelQ[$];
    logic      modelMis = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, compare outputs with the model, then advance the model across the edge.
    task automatic applyStimulus(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                                 input logic [31:0] ld, input logic rdy, input logic rs);
        int          n;
        logic        expFull;
        logic        expMis;
        logic        expHit;
        logic [31:0] expLd;
        logic [31:0] expAddr;
        logic [31:0] expData;
        logic        acc;
        logic        deq;
        sb_entry_t   e;

        sbIf.memwrite  = mw;
        sbIf.dataadr   = adr;
        sbIf.writedata = wd;
        sbIf.ld_addr   = ld;
        sbIf.mem_ready = rdy;
        rst            = rs;
        #1;

        n       = modelQ.size();
        expFull = (n == DEPTH);
        expMis  = mw && (adr[1:0] != 2'b00);
        expHit  = 1'b0;
        expLd   = 32'h0;
        for (int i = n - 1; i >= 0; i--) begin
            if (modelQ[i].addr[31:2] == ld[31:2]) begin
                expHit = 1'b1;
                expLd  = modelQ[i].data;
                break;
            end
        end
        expAddr = 32'h0;
        expData = 32'h0;
        if (n != 0) begin
            expAddr = modelQ[0].addr;
            expData = modelQ[0].data;
        end

        if (checkEn) begin
            checkOutput("stall",     32'(sbIf.stall),     32'(mw && expFull && !expMis));
            checkOutput("misalign",  32'(sbIf.misalign),  32'(modelMis));
            checkOutput("mem_valid", 32'(sbIf.mem_valid), 32'(n != 0));
            checkOutput("mem_addr",  sbIf.mem_addr,       expAddr);
            checkOutput("mem_wdata", sbIf.mem_wdata,      expData);
            checkOutput("empty",     32'(sbIf.empty),     32'(n == 0));
            checkOutput("count",     32'(sbIf.count),     32'(n));
            checkOutput("ld_hit",    32'(sbIf.ld_hit),    32'(expHit));
            checkOutput("ld_data",   sbIf.ld_data,        expLd);
        end

        @(posedge clk);
        if (rs) begin
            modelQ.delete();
            modelMis = 1'b0;
        end else begin
            deq = (n > 0) && rdy;
            acc = mw && !expFull && !expMis;
            if (deq) void'(modelQ.pop_front());
            if (acc) begin
                e.addr = adr;
                e.data = wd;
                modelQ.push_back(e);
            end
            modelMis = expMis;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rAdr;
        logic [31:0] rLd;

        rst            = 1'b1;
        sbIf.memwrite  = 1'b0;
        sbIf.dataadr   = '0;
        sbIf.writedata = '0;
        sbIf.ld_addr   = '0;
        sbIf.mem_ready = 1'b0;
        @(negedge clk);

        $display("[TB] reset");
        checkEn = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        checkEn = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        $display("[TB] single store with mem_ready high");
        applyStimulus(1'b1, 32'd80, 32'd7, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0, 32'd0, 1'b1, 1'b0);

        $display("[TB] fill, stall, held head, in-order drain");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'(80 + 4 * i), 32'(i + 1), 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd96, 32'd9, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("[TB] full with simultaneous dequeue, then retry");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'(80 + 4 * i), 32'(16 + i), 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd96, 32'd9, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'd96, 32'd9, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("[TB] forwarding, youngest match wins");
        applyStimulus(1'b1, 32'd84, 32'd5, 32'd86,  1'b0, 1'b0);
        applyStimulus(1'b1, 32'd84, 32'd7, 32'd86,  1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0, 32'd86,  1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0, 32'd100, 1'b0, 1'b0);

        $display("[TB] misaligned stores, including while full");
        applyStimulus(1'b1, 32'd82, 32'd3, 32'd86, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0, 32'd86, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0, 32'd86, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd88, 32'd1, 32'd88, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd92, 32'd2, 32'd88, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd90, 32'd4, 32'd88, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0, 32'd92, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 32'd0, 32'd0, 32'd92, 1'b1, 1'b0);

        $display("[TB] reset with entries pending");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'(84 + 4 * i), 32'(32 + i), 32'd84, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0,     32'd84, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0,  32'd0,     32'd84, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd84, 32'h55,    32'd84, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0,     32'd84, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0,  32'd0,     32'd84, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rAdr = 32'($urandom_range(0, 7)) << 2;
            if ($urandom_range(0, 3) == 0)
                rAdr[1:0] = 2'($urandom_range(1, 3));
            rLd = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), rAdr, $urandom, rLd,
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
